// File: rtl/out_port_pkg.sv
// Shared defaults for the CPU output-port receiver.
package out_port_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned DROP_CNT_W = 8;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : v + drop_cnt_t'(1);
    endfunction

endpackage

// File: rtl/out_port_rx_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module out_port_rx_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_port_rx.sv
// CPU output-port receiver: captures OUT_DATA into a FWFT FIFO, drops and flags words when full.
// Optional OUT_PORT_RX_DROP_CNT_EN adds an 8-bit saturating drop counter and the drop_cnt port.
module out_port_rx
    import out_port_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       OUT_EN,
    input  logic [DATA_W-1:0]          OUT_DATA,
    output logic                       rx_valid,
    output logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_ready,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
`ifdef OUT_PORT_RX_DROP_CNT_EN
    input  logic                       ovf_clr,
    output logic [DROP_CNT_W-1:0]      drop_cnt
`else
    input  logic                       ovf_clr
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, drop;

    assign rx_valid = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        pop  = rx_valid & rx_ready;
        // A pop frees the head slot this cycle, so a full FIFO still accepts the word.
        push = OUT_EN & (~full | pop);
        drop = OUT_EN & full & ~pop;

        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef OUT_PORT_RX_DROP_CNT_EN
    drop_cnt_t drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            drop_cnt_d = ovf_clr ? drop_cnt_t'(1) : sat_inc(drop_cnt_q);
        end else if (ovf_clr) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    out_port_rx_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (push),
        .waddr (wptr_q),
        .wdata (OUT_DATA),
        .raddr (rptr_q),
        .rdata (rx_data)
    );

endmodule

// File: tb/tb_out_port_rx.sv
// Scoreboard bench for out_port_rx: stimulus pushes expected words, a negedge monitor checks pops.
module tb_out_port_rx;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       OUT_EN;
    logic [7:0] OUT_DATA;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       ovf_clr;
`ifdef OUT_PORT_RX_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    out_port_rx #(.DEPTH(8), .DATA_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .OUT_EN   (OUT_EN),
        .OUT_DATA (OUT_DATA),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .full     (full),
        .count    (count),
        .overflow (overflow),
`ifdef OUT_PORT_RX_DROP_CNT_EN
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt)
`else
        .ovf_clr  (ovf_clr)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_drops(input int exp);
`ifdef OUT_PORT_RX_DROP_CNT_EN
        chk("drop_cnt", int'(drop_cnt), exp);
`else
        if (exp < 0) $display("unused %0d", exp);
`endif
    endtask

    // Monitor: a transfer happens on the coming edge whenever rx_valid & rx_ready.
    always @(negedge CLK) begin
        if (!RESET && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got=0x%0h expected=none", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    bad++;
                    $display("FAIL rx_data_order: got=0x%0h expected=0x%0h", rx_data, e);
                end
            end
        end
    end

    initial begin
        RESET = 1'b1; OUT_EN = 1'b0; OUT_DATA = '0; rx_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        tick();
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk_drops(0);

        // Single word round trip
        OUT_EN = 1'b1; OUT_DATA = 8'h5A; exp_q.push_back(8'h5A);
        tick();
        OUT_EN = 1'b0;
        chk("t1_valid", int'(rx_valid), 1);
        chk("t1_data", int'(rx_data), 8'h5A);
        chk("t1_count", int'(count), 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("t1_valid_after", int'(rx_valid), 0);
        chk("t1_count_after", int'(count), 0);

        // Fill to full
        for (int i = 1; i <= 8; i++) begin
            OUT_EN = 1'b1; OUT_DATA = 8'(i); exp_q.push_back(8'(i));
            tick();
        end
        OUT_EN = 1'b0;
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 8);

        // Drops while full
        OUT_DATA = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            OUT_EN = 1'b1;
            tick();
        end
        OUT_EN = 1'b0;
        chk("drop_overflow", int'(overflow), 1);
        chk_drops(3);
        chk("drop_count", int'(count), 8);
        chk("drop_head", int'(rx_data), 8'h01);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_overflow", int'(overflow), 0);
        chk_drops(0);

        // Clear and drop together: the drop wins
        OUT_EN = 1'b1; ovf_clr = 1'b1;
        tick();
        OUT_EN = 1'b0; ovf_clr = 1'b0;
        chk("clrdrop_overflow", int'(overflow), 1);
        chk_drops(1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr2_overflow", int'(overflow), 0);

        // Push and pop while full
        OUT_EN = 1'b1; OUT_DATA = 8'hAA; rx_ready = 1'b1; exp_q.push_back(8'hAA);
        tick();
        OUT_EN = 1'b0; rx_ready = 1'b0;
        chk("pp_count", int'(count), 8);
        chk("pp_full", int'(full), 1);
        chk("pp_overflow", int'(overflow), 0);
        chk("pp_head", int'(rx_data), 8'h02);

        // Drain, plus one extra ready cycle on empty
        rx_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        rx_ready = 1'b0;
        chk("drain_valid", int'(rx_valid), 0);
        chk("drain_count", int'(count), 0);
        chk("drain_queue", exp_q.size(), 0);

        // Streaming with pointer wrap
        rx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            OUT_EN = 1'b1; OUT_DATA = 8'(8'h10 + i); exp_q.push_back(8'(8'h10 + i));
            tick();
            if (count > 4'd1) chk("stream_count_le1", int'(count), 1);
        end
        chk("stream_count", int'(count), 1);
        OUT_EN = 1'b0;
        tick();
        rx_ready = 1'b0;
        chk("stream_overflow", int'(overflow), 0);
        chk("stream_end_count", int'(count), 0);
        chk("stream_queue", exp_q.size(), 0);

        // Reset mid-operation, with a push pending in the reset cycle
        for (int i = 0; i < 5; i++) begin
            OUT_EN = 1'b1; OUT_DATA = 8'(8'h40 + i);
            tick();
        end
        chk("pre_rst_count", int'(count), 5);
        RESET = 1'b1; OUT_DATA = 8'h77;
        tick();
        RESET = 1'b0; OUT_EN = 1'b0;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_valid", int'(rx_valid), 0);
        chk("mid_rst_overflow", int'(overflow), 0);
        OUT_EN = 1'b1; OUT_DATA = 8'h33; exp_q.push_back(8'h33);
        tick();
        OUT_EN = 1'b0;
        chk("post_rst_data", int'(rx_data), 8'h33);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("final_count", int'(count), 0);
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
